// File: rtl/fmul_pkg.sv
// fmul_pkg: shared state, rounding-mode and flag types for the sequential FP multiplier
package fmul_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MANT_W_DEF = 24;
  localparam int BIAS = 2**(EXP_W_DEF-1)-1;
  localparam int EXP_MAX = 2**EXP_W_DEF-1;
  localparam logic [EXP_W_DEF+MANT_W_DEF-1:0] QNAN = {1'b0, {EXP_W_DEF{1'b1}}, 1'b1, {(MANT_W_DEF-2){1'b0}}};
  typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;
  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RU  = 2'b01;
  localparam logic [1:0] RM_RD  = 2'b10;
  localparam logic [1:0] RM_RNE = 2'b11;
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;
endpackage

// File: rtl/fmul_seq_mant_rounding.sv
// mant_rounding: directed rounding of a normalised 2*MANT_W product down to MANT_W bits
module mant_rounding
  import fmul_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic [2*MANT_W-1:0] prod_i,
  input  logic                sign_i,
  input  logic [1:0]          mode_i,
  output logic [MANT_W-2:0]   frac_o,
  output logic                carry_o,
  output logic                inexact_o
);
  logic guard, sticky, inc;
  assign guard = prod_i[MANT_W-1];
  assign sticky = |prod_i[MANT_W-2:0];
  assign inexact_o = guard | sticky;
  assign inc = mode_i == RM_RNE ? guard & (sticky | prod_i[MANT_W]) :
               mode_i == RM_RU  ? inexact_o & ~sign_i :
               mode_i == RM_RD  ? inexact_o & sign_i : 1'b0;
  // the hidden bit is always set, so the fraction wraps to zero exactly on carry-out
  assign frac_o = prod_i[2*MANT_W-2:MANT_W] + {{(MANT_W-2){1'b0}}, inc};
  assign carry_o = inc & (&prod_i[2*MANT_W-1:MANT_W]);
endmodule

// File: rtl/fmul_seq.sv
// fmul_seq: multi-cycle IEEE-754 multiplier, shift-add mantissa and one shared rounder
// FMUL_RADIX4_EN: retire two multiplier bits per MULT cycle
module fmul_seq
  import fmul_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W-1:0] a,
  input  logic [EXP_W+MANT_W-1:0] b,
  input  logic [1:0]              rnd_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] result,
  output logic                    flag_inexact,
  output logic                    flag_overflow,
  output logic                    flag_underflow,
  output logic                    flag_invalid
);
  localparam int W = EXP_W + MANT_W;
  localparam int F = MANT_W - 1;
`ifdef FMUL_RADIX4_EN
  localparam int NSTEP = (MANT_W + 1) / 2;
  localparam int SH = 2;
`else
  localparam int NSTEP = MANT_W;
  localparam int SH = 1;
`endif
  localparam int CW = $clog2(NSTEP + 1);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);
  localparam logic signed [EXP_W+1:0] BS = (EXP_W+2)'(2**(EXP_W-1)-1);
  localparam logic [W-1:0] QN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};
  state_t state_q;
  logic sign_q, out_valid_q;
  logic [EXP_W-1:0] ea_q, eb_q, xa, xb;
  logic [F-1:0] fa, fb;
  logic [MANT_W-1:0] ma_q, mb_q;
  logic [1:0] rm_q;
  logic [2*MANT_W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic signed [EXP_W+1:0] exp_q, exp_d, exp_r;
  logic [W-1:0] result_q, result_d, spec_res;
  flags_t flags_q, flags_d, spec_flags;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, inv_c, nan_c, sgn_c, spec_c;
  logic [F-1:0] frac_r;
  logic cy_r, inx_r, ovf, unf, inf_sel;
  assign {xa, fa} = a[W-2:0];
  assign {xb, fb} = b[W-2:0];
  assign a_nan = &xa & |fa;
  assign b_nan = &xb & |fb;
  assign a_inf = &xa & ~|fa;
  assign b_inf = &xb & ~|fb;
  assign a_zero = ~|xa;
  assign b_zero = ~|xb;
  assign a_snan = a_nan & ~fa[F-1];
  assign b_snan = b_nan & ~fb[F-1];
  assign inv_c = (a_inf & b_zero) | (b_inf & a_zero);
  assign nan_c = a_nan | b_nan | inv_c;
  assign sgn_c = a[W-1] ^ b[W-1];
  assign spec_c = nan_c | a_inf | b_inf | a_zero | b_zero;
  assign spec_res = nan_c ? QN : (a_inf | b_inf) ? {sgn_c, {EXP_W{1'b1}}, {F{1'b0}}} : {sgn_c, {(W-1){1'b0}}};
  assign spec_flags = flags_t'({inv_c | a_snan | b_snan, 3'b000});
`ifdef FMUL_RADIX4_EN
  logic [MANT_W+1:0] ma3_q, pp, sum4;
  assign pp = mb_q[1:0] == 2'd3 ? ma3_q : mb_q[1] ? {1'b0, ma_q, 1'b0} : mb_q[0] ? {2'b00, ma_q} : '0;
  assign sum4 = {2'b00, acc_q[2*MANT_W-1:MANT_W]} + pp;
  assign acc_d = {sum4, acc_q[MANT_W-1:2]};
`else
  logic [MANT_W:0] sum2;
  assign sum2 = {1'b0, acc_q[2*MANT_W-1:MANT_W]} + (mb_q[0] ? {1'b0, ma_q} : '0);
  assign acc_d = {sum2, acc_q[MANT_W-1:1]};
`endif
  assign exp_d = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BS + $signed({{(EXP_W+1){1'b0}}, acc_q[2*MANT_W-1]});
  mant_rounding #(.MANT_W(MANT_W)) u_round (
    .prod_i(acc_q), .sign_i(sign_q), .mode_i(rm_q),
    .frac_o(frac_r), .carry_o(cy_r), .inexact_o(inx_r)
  );
  assign exp_r = exp_q + $signed({{(EXP_W+1){1'b0}}, cy_r});
  assign ovf = ~exp_r[EXP_W+1] & (exp_r[EXP_W] | &exp_r[EXP_W-1:0]);
  assign unf = exp_r[EXP_W+1] | ~|exp_r;
  assign inf_sel = rm_q == RM_RNE | (rm_q == RM_RU & ~sign_q) | (rm_q == RM_RD & sign_q);
  assign result_d = ovf ? (inf_sel ? {sign_q, {EXP_W{1'b1}}, {F{1'b0}}} : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {F{1'b1}}}) :
                    unf ? {sign_q, {(W-1){1'b0}}} : {sign_q, exp_r[EXP_W-1:0], frac_r};
  assign flags_d = flags_t'({1'b0, ovf, unf, inx_r | ovf | unf});
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      result_q <= '0;
      flags_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q <= sgn_c;
          ea_q <= xa;
          eb_q <= xb;
          ma_q <= {1'b1, fa};
          mb_q <= {1'b1, fb};
`ifdef FMUL_RADIX4_EN
          ma3_q <= {2'b01, fa} + {1'b1, fa, 1'b0};
`endif
          rm_q <= rnd_mode;
          acc_q <= '0;
          cnt_q <= '0;
          result_q <= spec_res;
          flags_q <= spec_flags;
          out_valid_q <= spec_c;
          state_q <= spec_c ? DONE : MULT;
        end
        MULT: begin
          acc_q <= acc_d;
          mb_q <= mb_q >> SH;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= NORM;
        end
        NORM: begin
          acc_q <= acc_q[2*MANT_W-1] ? acc_q : {acc_q[2*MANT_W-2:0], 1'b0};
          exp_q <= exp_d;
          state_q <= ROUND;
        end
        ROUND: begin
          result_q <= result_d;
          flags_q <= flags_d;
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign {flag_invalid, flag_overflow, flag_underflow, flag_inexact} = flags_q;
endmodule

// File: doc/fmul_seq.md
Name: fmul_seq

Overview:
- Multi-cycle IEEE-754 binary floating-point multiplier controller, single precision at defaults.
- Accepts operand pairs over a valid/ready handshake and unpacks them.
- Sequences an iterative shift-add mantissa multiply, then normalisation, the existing mant_rounding block, exponent/overflow/underflow fix-up and packing.
- Sits between the real-mult test wrapper and the rounding datapath, so one rounding instance serves every multiply.

Parameters:
- EXP_W, 8, exponent width; BIAS = 2^(EXP_W-1)-1.
- MANT_W, 24, significand width including the hidden bit; word width W = EXP_W+MANT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept
- a  in  W  operand A
- b  in  W  operand B
- rnd_mode  in  2  rounding mode: 00 zero, 01 +inf, 10 -inf, 11 nearest-even; captured at accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  W  packed product
- flag_inexact  out  1  result rounded
- flag_overflow  out  1  exponent overflow
- flag_underflow  out  1  flushed to zero
- flag_invalid  out  1  invalid operation

Behaviour:
- Reset, while rst is high: state=IDLE, in_ready=0, out_valid=0, result=0, all flags=0. in_ready=1 from the first cycle after rst falls. rst mid-operation aborts with no output.
- FSM states: IDLE, MULT, NORM, ROUND, DONE.
- in_ready=1 only in IDLE.
- Accept on in_valid&in_ready:
  - register sign = a[W-1]^b[W-1], biased exponents, significands with hidden bit, rnd_mode;
  - clear the 2*MANT_W product accumulator and the step counter;
  - go to DONE if a special case applies, else to MULT.
- Special cases, result available 1 cycle after accept:
  - any NaN operand, or inf*zero -> canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0);
  - flag_invalid=1 for inf*zero or a signalling NaN (exponent all ones, nonzero mantissa with MSB 0);
  - inf*finite-nonzero -> signed inf, no flags;
  - exponent field 0 on either operand (zero or denormal, flush-to-zero on input) -> signed zero, no flags.
- MULT:
  - one multiplier bit per cycle, LSB first;
  - add the multiplicand into the accumulator upper half when the bit is 1, then shift right one bit;
  - exactly MANT_W cycles; counter 0..MANT_W-1, then NORM.
- NORM:
  - exp = ea+eb-BIAS, computed in EXP_W+2 bits signed;
  - if product MSB is 1, exp+1 and pass the product unchanged;
  - else shift the product left 1.
- ROUND:
  - feed the 2*MANT_W normalised product, sign and mode to the rounder;
  - rounder increment rule: mode 00 none; 01 if positive and any low bit is set; 10 if negative and any low bit is set; 11 if guard&(sticky|round);
  - rounder carry-out -> exp+1, significand 1.000…;
  - flag_inexact = any discarded bit.
- Fix-up, in the same ROUND cycle:
  - exp >= 2^EXP_W-1: flag_overflow=1, flag_inexact=1. Result is inf for mode 11; for 01 if positive; for 10 if negative. Otherwise max finite (exponent 2^EXP_W-2, mantissa all ones).
  - exp <= 0: signed zero, flag_underflow=1, flag_inexact=1.
  - Then pack and go to DONE.
- DONE:
  - out_valid=1; result and flags held stable until out_ready.
  - On out_valid&out_ready: go to IDLE, out_valid=0 next cycle.
  - No same-cycle re-accept: one bubble between operations.
- Latency, accept edge to out_valid: MANT_W+2 cycles normal (26 at defaults), 1 cycle for specials. Throughput is one result per MANT_W+4 cycles with out_ready held high.
- Inputs are ignored outside IDLE. in_valid may drop without penalty.

Optional Feature:
- FMUL_RADIX4_EN defined: MULT retires two multiplier bits per cycle using partial products 0/1x/2x/3x, with 3x precomputed at accept. MULT takes ceil(MANT_W/2) cycles; normal latency is ceil(MANT_W/2)+2 (14 at defaults). Results and flags are bit-identical to the radix-2 build.
- Undefined: radix-2 as specified above.

Decomposition:
- Package fmul_pkg:
  - FSM state enum;
  - rounding-mode constants RM_RZ/RM_RU/RM_RD/RM_RNE;
  - BIAS, EXP_MAX and QNAN localparams derived from EXP_W/MANT_W;
  - flag bundle typedef.
- One sub-module instance: the existing mant_rounding block, purely combinational, driven from registered NORM outputs.
- Multiplier accumulator and FSM stay in fmul_seq.

Test Plan:
- 0x3FC00000 * 0x40000000, RNE -> 0x40400000, flags 0, out_valid exactly 26 cycles after accept.
- 0x3F800001 * 0x3F800001 -> RZ 0x3F800002, RU 0x3F800003, RD 0x3F800002, RNE 0x3F800002; inexact=1 in all modes.
- 0x7F7FFFFF * 0x40000000 -> RNE 0x7F800000, RZ 0x7F7FFFFF; overflow=1, inexact=1. 0xFF7FFFFF * 0x40000000 RU -> 0xFF7FFFFF.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1, out_valid 1 cycle after accept. 0x00800000 * 0x3F000000 -> 0x00000000, underflow=1, inexact=1.
- out_ready held low 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored; accept resumes the cycle after the handshake.
- rst pulsed for 1 cycle at MULT step 10 -> out_valid never rises for that operation, in_ready=1 the next cycle, and the following multiply is correct.
